// File: rtl/core_types_pkg.sv
// -----------------------------------------------------------------------------
// core_types_pkg
// Shared sizing constants, derived pointer widths and the retirement FSM
// state type used across the out-of-order core's retirement slice.
// No ports (package).
// -----------------------------------------------------------------------------
package core_types_pkg;

    localparam int ACTIVE_SIZE = 32;
    localparam int PHYS_REGS   = 64;
    localparam int FREE_SIZE   = 32;
    localparam int BRANCH_SIZE = 8;
    localparam int LQ_SIZE     = 8;
    localparam int SQ_SIZE     = 8;

    localparam int AW = $clog2(ACTIVE_SIZE);
    localparam int PW = $clog2(PHYS_REGS);
    localparam int FW = $clog2(FREE_SIZE);
    localparam int BW = $clog2(BRANCH_SIZE);
    localparam int LW = $clog2(LQ_SIZE);
    localparam int SW = $clog2(SQ_SIZE);

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        STORE_WAIT = 1'b1
    } retire_state_t;

endpackage : core_types_pkg

// File: rtl/retire_unit_if.sv
// -----------------------------------------------------------------------------
// retire_unit_if
// Bundles the active-list status read by the retirement engine, the D-cache
// store req/ack handshake and the commit pulses/pointers handed back to the
// state-update stage.
//   master : state-update stage / D-cache side (drives list status and ack)
//   slave  : retire_unit (drives commit outputs and store request)
// -----------------------------------------------------------------------------
interface retire_unit_if;
    import core_types_pkg::*;

    // active-list status
    logic [AW-1:0]                   youngest_ptr;
    logic                            youngest_wrap;
    logic [ACTIVE_SIZE-1:0]          ready_to_commit;
    logic [ACTIVE_SIZE-1:0]          is_load;
    logic [ACTIVE_SIZE-1:0]          is_store;
    logic [ACTIVE_SIZE-1:0]          is_branch;
    logic [ACTIVE_SIZE-1:0]          uses_rw;
    logic [ACTIVE_SIZE-1:0][4:0]     rw_addr;
    logic [ACTIVE_SIZE-1:0][PW-1:0]  reclaim_list;
    logic                            branch_miss;

    // store release handshake
    logic                            store_commit_req;
    logic                            store_commit_ack;

    // commit outputs
    logic                            commit_valid;
    logic [AW-1:0]                   commit_id;
    logic                            arch_we;
    logic [4:0]                      arch_addr;
    logic                            reclaim_valid;
    logic [PW-1:0]                   reclaim_preg;
    logic                            branch_done;
    logic                            load_done;
    logic                            store_done;
    logic [AW-1:0]                   oldest_ptr;
    logic [FW-1:0]                   free_tail_ptr;
    logic [BW-1:0]                   branch_read_ptr;
    logic [LW-1:0]                   load_commit_ptr;
    logic [SW-1:0]                   store_commit_ptr;
    logic                            active_empty;

    modport master (
        output youngest_ptr, youngest_wrap, ready_to_commit, is_load, is_store,
               is_branch, uses_rw, rw_addr, reclaim_list, branch_miss,
               store_commit_ack,
        input  store_commit_req, commit_valid, commit_id, arch_we, arch_addr,
               reclaim_valid, reclaim_preg, branch_done, load_done, store_done,
               oldest_ptr, free_tail_ptr, branch_read_ptr, load_commit_ptr,
               store_commit_ptr, active_empty
    );

    modport slave (
        input  youngest_ptr, youngest_wrap, ready_to_commit, is_load, is_store,
               is_branch, uses_rw, rw_addr, reclaim_list, branch_miss,
               store_commit_ack,
        output store_commit_req, commit_valid, commit_id, arch_we, arch_addr,
               reclaim_valid, reclaim_preg, branch_done, load_done, store_done,
               oldest_ptr, free_tail_ptr, branch_read_ptr, load_commit_ptr,
               store_commit_ptr, active_empty
    );

endinterface : retire_unit_if

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo-2^WIDTH pointer with a wrap bit that toggles every time the pointer
// rolls over from its maximum value back to 0.
//   clk, rst_n : clock, async active-low reset (clears value and wrap)
//   inc        : advance by one this edge
//   value      : current pointer
//   wrap       : toggles on each rollover
// -----------------------------------------------------------------------------
module wrap_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    // wrap bit is the carry out of the pointer, so one adder covers both
    logic [WIDTH:0] cnt_r;

    // pointer + wrap register, advances on inc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {(WIDTH+1){1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign value = cnt_r[WIDTH-1:0];
    assign wrap  = cnt_r[WIDTH];

endmodule : wrap_counter

// File: rtl/retire_unit.sv
// -----------------------------------------------------------------------------
// retire_unit
// In-order retirement engine. Retires at most one instruction per cycle from
// the oldest active-list entry. Non-store instructions retire in the cycle
// they become ready at the head; stores first move the FSM to STORE_WAIT and
// hold store_commit_req until the D-cache acks, retiring in the ack cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : retire_unit_if.slave (list status in, commit outputs out)
// -----------------------------------------------------------------------------
module retire_unit
    import core_types_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    retire_unit_if.slave  bus
);

    retire_state_t  state_r;
    logic           req_r;

    logic [AW-1:0]  oldest_s;
    logic           oldest_wrap_s;
    logic [FW-1:0]  free_tail_s;
    logic [BW-1:0]  branch_ptr_s;
    logic [LW-1:0]  load_ptr_s;
    logic [SW-1:0]  store_ptr_s;
    logic [3:0]     unused_wrap_s;

    logic           active_empty_s;
    logic           head_ok_s;
    logic           retire_s;
    logic           to_store_wait_s;
    logic           arch_we_s;
    logic           branch_done_s;
    logic           load_done_s;
    logic           store_done_s;
    logic [4:0]     arch_addr_s;
    logic [PW-1:0]  reclaim_preg_s;

    // head-of-list status and retire decision
    always_comb begin
        active_empty_s  = (oldest_s == bus.youngest_ptr) &&
                          (oldest_wrap_s == bus.youngest_wrap);
        head_ok_s       = !active_empty_s && bus.ready_to_commit[oldest_s] &&
                          !bus.branch_miss;
        retire_s        = 1'b0;
        to_store_wait_s = 1'b0;
        case (state_r)
            RUN: begin
                if (head_ok_s) begin
                    if (bus.is_store[oldest_s]) begin
                        to_store_wait_s = 1'b1;
                    end else begin
                        retire_s = 1'b1;
                    end
                end else begin
                    retire_s        = 1'b0;
                    to_store_wait_s = 1'b0;
                end
            end
            // the pending store is older than any branch under recovery,
            // so branch_miss does not hold it back
            STORE_WAIT: retire_s = bus.store_commit_ack;
            default:    retire_s = 1'b0;
        endcase
    end

    // per-retirement commit fields, all zero when nothing retires
    always_comb begin
        arch_we_s      = 1'b0;
        arch_addr_s    = 5'd0;
        reclaim_preg_s = {PW{1'b0}};
        branch_done_s  = 1'b0;
        load_done_s    = 1'b0;
        store_done_s   = 1'b0;
        if (retire_s) begin
            arch_we_s      = bus.uses_rw[oldest_s];
            arch_addr_s    = bus.rw_addr[oldest_s];
            reclaim_preg_s = bus.reclaim_list[oldest_s];
            if (bus.is_store[oldest_s]) begin
                store_done_s = 1'b1;
            end else if (bus.is_load[oldest_s]) begin
                load_done_s = 1'b1;
            end else if (bus.is_branch[oldest_s]) begin
                branch_done_s = 1'b1;
            end else begin
                store_done_s = 1'b0;
            end
        end else begin
            arch_we_s = 1'b0;
        end
    end

    // RUN/STORE_WAIT FSM with registered store request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            req_r   <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (to_store_wait_s) begin
                        state_r <= STORE_WAIT;
                        req_r   <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        req_r   <= 1'b0;
                    end
                end
                STORE_WAIT: begin
                    if (bus.store_commit_ack) begin
                        state_r <= RUN;
                        req_r   <= 1'b0;
                    end else begin
                        state_r <= STORE_WAIT;
                        req_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= RUN;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    wrap_counter #(.WIDTH(AW)) u_oldest (
        .clk(clk), .rst_n(rst_n), .inc(retire_s),
        .value(oldest_s), .wrap(oldest_wrap_s)
    );
    wrap_counter #(.WIDTH(FW)) u_free_tail (
        .clk(clk), .rst_n(rst_n), .inc(arch_we_s),
        .value(free_tail_s), .wrap(unused_wrap_s[0])
    );
    wrap_counter #(.WIDTH(BW)) u_branch (
        .clk(clk), .rst_n(rst_n), .inc(branch_done_s),
        .value(branch_ptr_s), .wrap(unused_wrap_s[1])
    );
    wrap_counter #(.WIDTH(LW)) u_load (
        .clk(clk), .rst_n(rst_n), .inc(load_done_s),
        .value(load_ptr_s), .wrap(unused_wrap_s[2])
    );
    wrap_counter #(.WIDTH(SW)) u_store (
        .clk(clk), .rst_n(rst_n), .inc(store_done_s),
        .value(store_ptr_s), .wrap(unused_wrap_s[3])
    );

    assign bus.store_commit_req = req_r;
    assign bus.commit_valid     = retire_s;
    assign bus.commit_id        = oldest_s;
    assign bus.arch_we          = arch_we_s;
    assign bus.arch_addr        = arch_addr_s;
    assign bus.reclaim_valid    = arch_we_s;
    assign bus.reclaim_preg     = reclaim_preg_s;
    assign bus.branch_done      = branch_done_s;
    assign bus.load_done        = load_done_s;
    assign bus.store_done       = store_done_s;
    assign bus.oldest_ptr       = oldest_s;
    assign bus.free_tail_ptr    = free_tail_s;
    assign bus.branch_read_ptr  = branch_ptr_s;
    assign bus.load_commit_ptr  = load_ptr_s;
    assign bus.store_commit_ptr = store_ptr_s;
    assign bus.active_empty     = active_empty_s;

endmodule : retire_unit

// File: tb/tb_retire_unit.sv
// -----------------------------------------------------------------------------
// tb_retire_unit
// Directed bench for retire_unit: ALU burst, delayed store ack, branch_miss
// stall, pointer wrap with loads, full list drain, async reset in STORE_WAIT.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_retire_unit;
    import core_types_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    retire_unit_if rif ();

    retire_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_list();
        rif.ready_to_commit = '0;
        rif.is_load         = '0;
        rif.is_store        = '0;
        rif.is_branch       = '0;
        rif.uses_rw         = '0;
        rif.rw_addr         = '0;
        rif.reclaim_list    = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clear_list();
        rif.youngest_ptr     = '0;
        rif.youngest_wrap    = 1'b0;
        rif.branch_miss      = 1'b0;
        rif.store_commit_ack = 1'b0;

        // reset state
        #2;
        chk("rst_commit_valid", 32'(rif.commit_valid), 32'd0);
        chk("rst_req",          32'(rif.store_commit_req), 32'd0);
        chk("rst_empty",        32'(rif.active_empty), 32'd1);
        chk("rst_oldest",       32'(rif.oldest_ptr), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // three ready ALU ops, one per cycle
        for (int i = 0; i < 3; i++) begin
            rif.ready_to_commit[i] = 1'b1;
            rif.uses_rw[i]         = 1'b1;
            rif.rw_addr[i]         = 5'(i + 1);
            rif.reclaim_list[i]    = PW'(i + 10);
        end
        rif.youngest_ptr = AW'(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("alu_commit_valid", 32'(rif.commit_valid), 32'd1);
            chk("alu_commit_id",    32'(rif.commit_id), 32'(i));
            chk("alu_reclaim_preg", 32'(rif.reclaim_preg), 32'(i + 10));
            chk("alu_arch_addr",    32'(rif.arch_addr), 32'(i + 1));
            chk("alu_reclaim_vld",  32'(rif.reclaim_valid), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("alu_after_valid", 32'(rif.commit_valid), 32'd0);
        chk("alu_free_tail",   32'(rif.free_tail_ptr), 32'd3);
        chk("alu_empty",       32'(rif.active_empty), 32'd1);
        tick();

        // store at head (entry 3); stray ack in RUN must be ignored
        clear_list();
        rif.ready_to_commit[3] = 1'b1;
        rif.is_store[3]        = 1'b1;
        rif.youngest_ptr       = AW'(4);
        rif.store_commit_ack   = 1'b1;
        @(negedge clk);
        chk("st_run_no_commit", 32'(rif.commit_valid), 32'd0);
        chk("st_run_no_req",    32'(rif.store_commit_req), 32'd0);
        tick();
        rif.store_commit_ack = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            rif.store_commit_ack = (c == 4) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk("st_req_held", 32'(rif.store_commit_req), 32'd1);
            chk("st_commit",   32'(rif.commit_valid), (c == 4) ? 32'd1 : 32'd0);
            chk("st_done",     32'(rif.store_done), (c == 4) ? 32'd1 : 32'd0);
            tick();
        end
        rif.store_commit_ack = 1'b0;
        @(negedge clk);
        chk("st_ptr_before_chk", 32'(rif.commit_valid), 32'd0);
        chk("st_req_drop",       32'(rif.store_commit_req), 32'd0);
        chk("st_ptr_after",      32'(rif.store_commit_ptr), 32'd1);
        chk("st_oldest",         32'(rif.oldest_ptr), 32'd4);
        tick();

        // branch at head during branch_miss stalls one cycle
        clear_list();
        rif.ready_to_commit[4] = 1'b1;
        rif.is_branch[4]       = 1'b1;
        rif.youngest_ptr       = AW'(5);
        rif.branch_miss        = 1'b1;
        @(negedge clk);
        chk("br_miss_stall", 32'(rif.commit_valid), 32'd0);
        tick();
        rif.branch_miss = 1'b0;
        @(negedge clk);
        chk("br_commit",   32'(rif.commit_valid), 32'd1);
        chk("br_done",     32'(rif.branch_done), 32'd1);
        chk("br_ptr_pre",  32'(rif.branch_read_ptr), 32'd0);
        chk("br_id",       32'(rif.commit_id), 32'd4);
        tick();
        @(negedge clk);
        chk("br_ptr_post", 32'(rif.branch_read_ptr), 32'd1);
        chk("br_empty",    32'(rif.active_empty), 32'd1);
        tick();

        // walk head to 31, then two loads across the wrap
        clear_list();
        rif.ready_to_commit = '1;
        rif.is_load[31]     = 1'b1;
        rif.is_load[0]      = 1'b1;
        rif.youngest_ptr    = AW'(31);
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            chk("walk_id", 32'(rif.commit_id), 32'(5 + k));
            tick();
        end
        @(negedge clk);
        chk("walk_stop",   32'(rif.commit_valid), 32'd0);
        chk("walk_oldest", 32'(rif.oldest_ptr), 32'd31);
        tick();
        rif.youngest_ptr  = AW'(1);
        rif.youngest_wrap = 1'b1;
        @(negedge clk);
        chk("ld_id31",   32'(rif.commit_id), 32'd31);
        chk("ld_done0",  32'(rif.load_done), 32'd1);
        chk("ld_ptr0",   32'(rif.load_commit_ptr), 32'd0);
        tick();
        @(negedge clk);
        chk("ld_id0",    32'(rif.commit_id), 32'd0);
        chk("ld_done1",  32'(rif.load_done), 32'd1);
        chk("ld_ptr1",   32'(rif.load_commit_ptr), 32'd1);
        tick();
        @(negedge clk);
        chk("ld_ptr2",      32'(rif.load_commit_ptr), 32'd2);
        chk("ld_wrap_empty", 32'(rif.active_empty), 32'd1);
        tick();

        // full list: pointers equal (1), wraps differ
        clear_list();
        rif.ready_to_commit = '1;
        rif.uses_rw         = '1;
        rif.youngest_ptr    = AW'(1);
        rif.youngest_wrap   = 1'b0;
        @(negedge clk);
        chk("full_not_empty", 32'(rif.active_empty), 32'd0);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            chk("full_id", 32'(rif.commit_id), 32'((1 + k) % 32));
            chk("full_valid", 32'(rif.commit_valid), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("full_empty",     32'(rif.active_empty), 32'd1);
        chk("full_free_tail", 32'(rif.free_tail_ptr), 32'd3);
        tick();

        // async reset while waiting for a store ack
        clear_list();
        rif.ready_to_commit[1] = 1'b1;
        rif.is_store[1]        = 1'b1;
        rif.youngest_ptr       = AW'(2);
        tick();
        @(negedge clk);
        chk("ar_req_up", 32'(rif.store_commit_req), 32'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req_drop",  32'(rif.store_commit_req), 32'd0);
        chk("ar_st_done",   32'(rif.store_done), 32'd0);
        chk("ar_oldest",    32'(rif.oldest_ptr), 32'd0);
        chk("ar_free",      32'(rif.free_tail_ptr), 32'd0);
        chk("ar_br",        32'(rif.branch_read_ptr), 32'd0);
        chk("ar_ld",        32'(rif.load_commit_ptr), 32'd0);
        chk("ar_st",        32'(rif.store_commit_ptr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("ar_post_valid", 32'(rif.commit_valid), 32'd0);
        chk("ar_post_req",   32'(rif.store_commit_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_retire_unit
